// File: rtl/heap_sort_pkg.sv
// Shared types and constants for the parametrised heap sorter.
// The optional cycle counter in heap_sort_param is built only when SORT_PERF_EN is defined.
package heap_sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUILD,
        HEAPIFY,
        WRITE,
        EXTRACT,
        FIN
    } state_t;

    // Where HEAPIFY returns once the sift-down settles.
    typedef enum logic {
        RET_BUILD,
        RET_WRITE
    } ret_t;

    // Worst-case busy cycles for a sort of n elements (n a power of 2).
    function automatic int worst_case_cycles(input int n);
        int lg;
        lg = $clog2(n);
        return n + (n / 2) * (1 + lg) + n * (2 + lg) + 2;
    endfunction

    localparam int MAX_CYCLES_DEFAULT = worst_case_cycles(16);

endpackage

// File: rtl/heap_child_select.sv
// Picks which of node idx and its two children should sit at idx:
// the largest for a max-heap (desc=0) or the smallest for a min-heap (desc=1).
module heap_child_select
    import heap_sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IW     = 6
) (
    input  logic [IW-1:0]     idx,
    input  logic [IW-1:0]     num,
    input  logic [DATA_W-1:0] val_idx,
    input  logic [DATA_W-1:0] val_l,
    input  logic [DATA_W-1:0] val_r,
    input  logic              desc,
    output logic [IW-1:0]     pick
);

    logic [IW-1:0]     l_idx;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] best;

    // NOTE: blocking assignments here are deliberate; best must carry the left
    // child's value into the right-child comparison within the same evaluation.
    always_comb begin
        l_idx = idx << 1;
        r_idx = l_idx | IW'(1);
        pick  = idx;
        best  = val_idx;
        // Strict comparisons: ties keep idx, and the left child wins over the right.
        if (l_idx <= num && (desc ? (val_l < best) : (val_l > best))) begin
            pick = l_idx;
            best = val_l;
        end
        if (r_idx <= num && (desc ? (val_r < best) : (val_r > best))) begin
            pick = r_idx;
        end
    end

endmodule

// File: rtl/heap_sort_param.sv
// Heap sorter: loads N words from an async ROM, heap-sorts them in place and writes
// them to RAM 0..N-1 ascending or descending. Define SORT_PERF_EN to build cycle_count.
module heap_sort_param
    import heap_sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CW-1:0]     num_elems,
    input  logic              desc,
    output logic              busy,
    output logic              done,
    output logic              rom_rd,
    output logic [AW-1:0]     rom_a,
    input  logic [DATA_W-1:0] rom_q,
    output logic              ram_valid,
    output logic [AW-1:0]     ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic [31:0]       cycle_count
);

    // One extra bit so child index 2*idx+1 cannot wrap at DEPTH.
    localparam int IW = CW + 1;

    state_t            state, state_n;
    ret_t              ret, ret_n;
    logic              desc_r, desc_n;
    logic [IW-1:0]     num, num_n;
    logic [IW-1:0]     ld_cnt, ld_cnt_n;
    logic [IW-1:0]     i_cnt, i_cnt_n;
    logic [IW-1:0]     idx, idx_n;

    logic [DATA_W-1:0] heap [1:DEPTH];

    logic              wr0_en, wr1_en;
    logic [IW-1:0]     wr0_a, wr1_a;
    logic [DATA_W-1:0] wr0_d, wr1_d;

    logic [IW-1:0]     l_idx, r_idx, pick;
    logic [DATA_W-1:0] val_idx, val_l, val_r, val_pick, val_last;
    logic [CW-1:0]     n_clamp;

    // Out-of-range indices read as 0; callers mask them with the heap size anyway.
    function automatic logic [DATA_W-1:0] heap_rd(input logic [IW-1:0] a);
        heap_rd = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (a == IW'(k)) heap_rd = heap[k];
        end
    endfunction

    assign l_idx    = idx << 1;
    assign r_idx    = l_idx | IW'(1);
    assign val_idx  = heap_rd(idx);
    assign val_l    = heap_rd(l_idx);
    assign val_r    = heap_rd(r_idx);
    assign val_last = heap_rd(num);
    assign val_pick = (pick == l_idx) ? val_l : val_r;
    assign n_clamp  = (num_elems > CW'(DEPTH)) ? CW'(DEPTH) : num_elems;

    heap_child_select #(
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_child_select (
        .idx     (idx),
        .num     (num),
        .val_idx (val_idx),
        .val_l   (val_l),
        .val_r   (val_r),
        .desc    (desc_r),
        .pick    (pick)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n  = state;
        ret_n    = ret;
        desc_n   = desc_r;
        num_n    = num;
        ld_cnt_n = ld_cnt;
        i_cnt_n  = i_cnt;
        idx_n    = idx;
        wr0_en   = 1'b0;
        wr0_a    = idx;
        wr0_d    = val_pick;
        wr1_en   = 1'b0;
        wr1_a    = pick;
        wr1_d    = val_idx;

        case (state)
            IDLE: begin
                if (start) begin
                    if (n_clamp == '0) begin
                        state_n = FIN;
                    end else begin
                        num_n    = IW'(n_clamp);
                        desc_n   = desc;
                        ld_cnt_n = '0;
                        state_n  = LOAD;
                    end
                end
            end
            LOAD: begin
                wr0_en   = 1'b1;
                wr0_a    = ld_cnt + IW'(1);
                wr0_d    = rom_q;
                ld_cnt_n = ld_cnt + IW'(1);
                if (ld_cnt == num - IW'(1)) begin
                    if (num == IW'(1)) begin
                        state_n = WRITE;
                    end else begin
                        i_cnt_n = num >> 1;
                        state_n = BUILD;
                    end
                end
            end
            BUILD: begin
                idx_n   = i_cnt;
                i_cnt_n = i_cnt - IW'(1);
                ret_n   = (i_cnt > IW'(1)) ? RET_BUILD : RET_WRITE;
                state_n = HEAPIFY;
            end
            HEAPIFY: begin
                if (pick != idx) begin
                    wr0_en = 1'b1;
                    wr1_en = 1'b1;
                    idx_n  = pick;
                end else begin
                    state_n = (ret == RET_BUILD) ? BUILD : WRITE;
                end
            end
            WRITE: begin
                state_n = (num == IW'(1)) ? FIN : EXTRACT;
            end
            EXTRACT: begin
                wr0_en  = 1'b1;
                wr0_a   = IW'(1);
                wr0_d   = val_last;
                num_n   = num - IW'(1);
                idx_n   = IW'(1);
                ret_n   = RET_WRITE;
                state_n = HEAPIFY;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ret    <= RET_BUILD;
            desc_r <= 1'b0;
            num    <= '0;
            ld_cnt <= '0;
            i_cnt  <= '0;
            idx    <= '0;
        end else begin
            state  <= state_n;
            ret    <= ret_n;
            desc_r <= desc_n;
            num    <= num_n;
            ld_cnt <= ld_cnt_n;
            i_cnt  <= i_cnt_n;
            idx    <= idx_n;
        end
    end

    // NOTE: the heap array is not reset; every entry is loaded before it is read.
    always_ff @(posedge clk) begin
        for (int k = 1; k <= DEPTH; k++) begin
            if (wr0_en && wr0_a == IW'(k)) begin
                heap[k] <= wr0_d;
            end else if (wr1_en && wr1_a == IW'(k)) begin
                heap[k] <= wr1_d;
            end
        end
    end

    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);
    assign rom_rd    = (state == LOAD);
    assign rom_a     = ld_cnt[AW-1:0];
    assign ram_valid = (state == WRITE);
    // The root is written to the highest remaining address, so the order falls out of the heap type.
    assign ram_a     = ram_valid ? AW'(num - IW'(1)) : '0;
    assign ram_d     = ram_valid ? heap[1] : '0;

`ifdef SORT_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (state == IDLE && start) begin
            perf_cnt <= '0;
        end else if (busy) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign cycle_count = perf_cnt;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: doc/heap_sort_param.md
Name: heap_sort_param

Overview:
Parametrised heap sorter and successor to the fixed 16-entry byte sorter. On `start` it reads N = `num_elems` words from an asynchronous ROM and heap-sorts them in an internal 1-indexed array. It writes the sorted result to RAM addresses 0..N-1, ascending or descending per `desc`. It sits between the ROM loader and the RAM consumer, and adds a start/busy/done handshake, runtime length and runtime order selection.

Parameters:
- DATA_W, default 8: element width in bits.
- DEPTH, default 16: maximum element count; power of 2, ≥ 2.
- AW, default $clog2(DEPTH): ROM/RAM address width.
- CW, default $clog2(DEPTH)+1: width of `num_elems`.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begin a sort; accepted only when `busy`=0.
- num_elems, in, CW: element count N, 0..DEPTH; sampled when `start` is accepted.
- desc, in, 1: order select, 0=ascending, 1=descending; sampled when `start` is accepted.
- busy, out, 1: high from the cycle after start is accepted until the done cycle.
- done, out, 1: one-cycle pulse when the sort is complete.
- rom_rd, out, 1: high in LOAD.
- rom_a, out, AW: ROM address.
- rom_q, in, DATA_W: ROM data, combinational on `rom_a` (valid in the same cycle).
- ram_valid, out, 1: RAM write strobe, one cycle per element.
- ram_a, out, AW: RAM address.
- ram_d, out, DATA_W: RAM write data.
- cycle_count, out, 32: see Optional Feature.

Behaviour:
- Reset (synchronous) takes effect at the next edge and overrides any operation in progress:
  - all outputs go to 0; state goes to IDLE;
  - heap contents are don't-care;
  - `ram_valid` is 0 the cycle after reset is sampled.
- IDLE:
  - On `start` with N≥1: latch N and `desc`, set `rom_a`=0, go to LOAD.
  - On `start` with N=0: go to FIN (no reads, no writes).
  - `start` while `busy` is ignored.
- LOAD, N cycles:
  - each cycle: A[`rom_a`+1] <= `rom_q`, `rom_a`++;
  - after N loads, go to BUILD with i=N/2;
  - if N=1, go straight to WRITE.
- BUILD: one cycle. Set idx=i, then i--. Return target is BUILD if i>1, else WRITE. Go to HEAPIFY.
- HEAPIFY, one cycle per tree level:
  - l=2·idx, r=2·idx+1, considered only if ≤ current heap size `num`;
  - ascending (max-heap): pick the largest of idx, l, r;
  - descending (min-heap): pick the smallest;
  - ties keep idx, and prefer l over r;
  - if the pick ≠ idx: swap A[idx] with A[pick], idx<=pick, stay in HEAPIFY;
  - if the pick = idx: go to the return target.
- WRITE: one cycle.
  - `ram_valid`=1, `ram_d`=A[1], `ram_a`=`num`-1, so the first write goes to N-1 and the last to 0.
  - If `num`=1, go to FIN; else go to EXTRACT.
- EXTRACT: one cycle. `ram_valid`=0, A[1]<=A[`num`], `num`--, idx=1, return target=WRITE, go to HEAPIFY.
- FIN: `done`=1 for one cycle, `busy`=0, go to IDLE.
- Result: ram[0..N-1] is non-decreasing when `desc`=0 and non-increasing when `desc`=1.
- Strobe guarantees: exactly N `ram_valid` pulses per sort; each address 0..N-1 is written exactly once; `ram_valid` is never high on two consecutive cycles.
- Latency is data-dependent, with worst case ≤ N + N/2·(1+log2N) + N·(2+log2N) + 2 cycles.
- Width rules: `num` and all indices use CW+1 bits, so child index 2·idx+1 never overflows at DEPTH.
- `num_elems` > DEPTH is clamped to DEPTH.

Optional Feature:
- Macro: SORT_PERF_EN.
- Defined: `cycle_count` clears on start accept, increments every busy cycle, and holds its value after `done` until the next start or reset.
- Undefined: `cycle_count` is tied to 0 and no counter logic is built.

Decomposition:
- Package `heap_sort_pkg` holds:
  - the state enum (IDLE, LOAD, BUILD, HEAPIFY, WRITE, EXTRACT, FIN);
  - the return-target encoding;
  - a localparam for the worst-case cycle bound.
- Sub-module `heap_child_select` (combinational): inputs idx, `num`, A[idx], A[l], A[r], `desc`; output pick index.

Test Plan:
1. N=16, `desc`=0, ROM={5,3,17,10,84,19,6,22,9,35,1,60,8,14,2,99} → ram[0..15]={1,2,3,5,6,8,9,10,14,17,19,22,35,60,84,99}; 16 `ram_valid` pulses; one `done` pulse.
2. Same ROM, `desc`=1 → ram[0]=99 … ram[15]=1; first write at `ram_a`=15.
3. N=1, ROM[0]=0xAB → no BUILD; single write ram[0]=0xAB; N=0 → `done` 1 cycle after start, zero writes, zero ROM reads.
4. N=7 with duplicates {4,4,0xFF,0,4,0xFF,0} → ascending ram[0..6]={0,0,4,4,4,0xFF,0xFF}; ram[7..15] untouched.
5. Assert reset during HEAPIFY in the first extract → next cycle all outputs 0; restart with N=16 reproduces the result of case 1; `start` pulsed while `busy` has no effect.
6. With SORT_PERF_EN, case 1 → `cycle_count` equals the bench-counted busy cycles and is ≤ the bound; without the macro, `cycle_count`=0 throughout.
